// File: rtl/biriscv_pipe_ctrl_nstage_if.sv
// ---------------------------------------------------------------------------
// biriscv_pipe_ctrl_nstage_if
// Bundles every non-clock/reset signal of the N-stage pipeline controller.
//   master : issue/decode + LSU + MUL + regfile side (drives *_i, reads *_o)
//   slave  : the pipeline controller itself
// Signal groups:
//   issue_*           issue handshake, global stall, class bits, rd, pc, exc
//   alu/mem/mul_*     execution results captured at their stages
//   ra_i/rb_i, fwd_*  two-operand forwarding lookup, hazard_o
//   stall_o/squash_o  memory stall request and exception flush
//   squash_wb_i, *_wb_o  writeback kill and commit outputs
// ---------------------------------------------------------------------------
interface biriscv_pipe_ctrl_nstage_if;
    logic        issue_valid_i;
    logic        issue_accept_i;
    logic        issue_stall_i;
    logic        issue_lsu_i;
    logic        issue_mul_i;
    logic        issue_rd_valid_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] issue_pc_i;
    logic [5:0]  issue_exception_i;
    logic [31:0] alu_result_e1_i;
    logic        mem_complete_i;
    logic [31:0] mem_result_i;
    logic [5:0]  mem_exception_i;
    logic [31:0] mul_result_i;
    logic [4:0]  ra_i;
    logic [4:0]  rb_i;
    logic        fwd_ra_valid_o;
    logic        fwd_rb_valid_o;
    logic [31:0] fwd_ra_o;
    logic [31:0] fwd_rb_o;
    logic        hazard_o;
    logic        stall_o;
    logic        squash_o;
    logic        squash_wb_i;
    logic        valid_wb_o;
    logic [4:0]  rd_wb_o;
    logic [31:0] result_wb_o;
    logic [31:0] pc_wb_o;
    logic [5:0]  exception_wb_o;

    modport master (
        output issue_valid_i, issue_accept_i, issue_stall_i, issue_lsu_i,
               issue_mul_i, issue_rd_valid_i, issue_rd_i, issue_pc_i,
               issue_exception_i, alu_result_e1_i, mem_complete_i,
               mem_result_i, mem_exception_i, mul_result_i, ra_i, rb_i,
               squash_wb_i,
        input  fwd_ra_valid_o, fwd_rb_valid_o, fwd_ra_o, fwd_rb_o, hazard_o,
               stall_o, squash_o, valid_wb_o, rd_wb_o, result_wb_o, pc_wb_o,
               exception_wb_o
    );

    modport slave (
        input  issue_valid_i, issue_accept_i, issue_stall_i, issue_lsu_i,
               issue_mul_i, issue_rd_valid_i, issue_rd_i, issue_pc_i,
               issue_exception_i, alu_result_e1_i, mem_complete_i,
               mem_result_i, mem_exception_i, mul_result_i, ra_i, rb_i,
               squash_wb_i,
        output fwd_ra_valid_o, fwd_rb_valid_o, fwd_ra_o, fwd_rb_o, hazard_o,
               stall_o, squash_o, valid_wb_o, rd_wb_o, result_wb_o, pc_wb_o,
               exception_wb_o
    );
endinterface

// File: rtl/biriscv_pipe_ctrl_nstage.sv
// ---------------------------------------------------------------------------
// biriscv_pipe_ctrl_nstage
// In-order execute pipeline controller: E1..E<STAGES> followed by one WB
// register. Captures ALU (E1), load (MEM_STAGE) and multiply (MUL_STAGE)
// results, raises the memory stall, squashes on exceptions reaching the last
// stage, and answers a two-operand RAW forwarding/hazard lookup.
// Ports:
//   clk_i  clock, rst_i synchronous active-high reset
//   bus    biriscv_pipe_ctrl_nstage_if.slave (issue, results, lookup, WB)
// Parameters: STAGES (2..6), MEM_STAGE, MUL_STAGE (both 2..STAGES).
// Build option: BIRISCV_PIPE_FWD_EN enables the forwarding network; when
// undefined no value is forwarded and any in-flight match is a hazard.
// ---------------------------------------------------------------------------
module biriscv_pipe_ctrl_nstage #(
    parameter int STAGES    = 3,
    parameter int MEM_STAGE = 2,
    parameter int MUL_STAGE = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    biriscv_pipe_ctrl_nstage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic        lsu;
        logic        mul;
        logic        rd_valid;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [5:0]  exc;
        logic [31:0] result;
        logic        ready;
    } entry_t;

    entry_t      r_st  [1:STAGES];
    entry_t      w_adv [1:STAGES];   // stage k entry as it leaves stage k
    entry_t      w_issue;
    logic        r_squash;
    logic        r_wb_valid;
    logic        r_wb_rd_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_pc;
    logic [31:0] r_wb_result;
    logic [5:0]  r_wb_exc;

    logic        w_squash_now;
    logic        w_squash;
    logic        w_accept;
    logic        w_valid_wb;
    logic [1:0][4:0]  w_src;
    logic [1:0]       w_hit;
    logic [1:0]       w_fv;
    logic [1:0][31:0] w_fd;
    logic [1:0]       w_hz;

    // Result capture applied on the move out of each stage.
    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            w_adv[k] = r_st[k];
            if (k == 1 && !r_st[k].lsu && !r_st[k].mul) begin
                w_adv[k].result = bus.alu_result_e1_i;
                w_adv[k].ready  = 1'b1;
            end
            if (k == MEM_STAGE && r_st[k].lsu) begin
                w_adv[k].result = bus.mem_result_i;
                w_adv[k].ready  = 1'b1;
                // Front-end exception takes precedence over the LSU one.
                if (r_st[k].exc == 6'd0)
                    w_adv[k].exc = bus.mem_exception_i;
            end
            if (k == MUL_STAGE && r_st[k].mul) begin
                w_adv[k].result = bus.mul_result_i;
                w_adv[k].ready  = 1'b1;
            end
        end
    end

    always_comb begin
        w_issue          = '0;
        w_issue.valid    = 1'b1;
        w_issue.lsu      = bus.issue_lsu_i;
        w_issue.mul      = bus.issue_mul_i;
        w_issue.rd_valid = bus.issue_rd_valid_i;
        w_issue.rd       = bus.issue_rd_i;
        w_issue.pc       = bus.issue_pc_i;
        w_issue.exc      = bus.issue_exception_i;
    end

    // w_adv covers a load whose mem exception arrives in the last stage.
    assign w_squash_now = r_st[STAGES].valid && (w_adv[STAGES].exc != 6'd0);
    assign w_squash     = w_squash_now | r_squash;
    assign w_accept     = bus.issue_valid_i & bus.issue_accept_i & ~w_squash;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= STAGES; k++)
                r_st[k] <= '0;
            r_squash      <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_rd_valid <= 1'b0;
            r_wb_rd       <= 5'd0;
            r_wb_pc       <= 32'd0;
            r_wb_result   <= 32'd0;
            r_wb_exc      <= 6'd0;
        end else if (!bus.issue_stall_i) begin
            r_squash <= w_squash_now;
            if (w_accept)
                r_st[1] <= w_issue;
            else
                r_st[1] <= '0;
            for (int k = 2; k <= STAGES; k++) begin
                if (w_squash)
                    r_st[k] <= '0;
                else
                    r_st[k] <= w_adv[k-1];
            end
            if (bus.squash_wb_i) begin
                r_wb_valid    <= 1'b0;
                r_wb_rd_valid <= 1'b0;
                r_wb_rd       <= 5'd0;
                r_wb_pc       <= 32'd0;
                r_wb_result   <= 32'd0;
                r_wb_exc      <= 6'd0;
            end else begin
                // Excepting entry commits nothing but keeps its code.
                r_wb_valid    <= w_adv[STAGES].valid & ~w_squash_now;
                r_wb_rd_valid <= w_adv[STAGES].rd_valid & ~w_squash_now;
                r_wb_rd       <= w_adv[STAGES].rd;
                r_wb_pc       <= w_adv[STAGES].pc;
                r_wb_result   <= w_adv[STAGES].result;
                r_wb_exc      <= w_adv[STAGES].exc;
            end
        end
    end

    // Forwarding lookup, youngest stage first, WB last.
    assign w_src = {bus.rb_i, bus.ra_i};

    always_comb begin
        w_hit = '0;
        w_fv  = '0;
        w_fd  = '0;
        w_hz  = '0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= STAGES; k++) begin
                if (!w_hit[p] && r_st[k].valid && r_st[k].rd_valid &&
                    r_st[k].rd == w_src[p] && w_src[p] != 5'd0) begin
                    w_hit[p] = 1'b1;
`ifdef BIRISCV_PIPE_FWD_EN
                    if (r_st[k].ready) begin
                        w_fv[p] = 1'b1;
                        w_fd[p] = r_st[k].result;
                    end else if (k == 1 && !r_st[k].lsu && !r_st[k].mul) begin
                        w_fv[p] = 1'b1;
                        w_fd[p] = bus.alu_result_e1_i;
                    end else if (k == MEM_STAGE && r_st[k].lsu && bus.mem_complete_i) begin
                        w_fv[p] = 1'b1;
                        w_fd[p] = bus.mem_result_i;
                    end else begin
                        w_hz[p] = 1'b1;
                    end
`else
                    w_hz[p] = 1'b1;
`endif
                end
            end
            if (!w_hit[p] && r_wb_valid && r_wb_rd_valid &&
                r_wb_rd == w_src[p] && w_src[p] != 5'd0) begin
                w_hit[p] = 1'b1;
`ifdef BIRISCV_PIPE_FWD_EN
                w_fv[p] = 1'b1;
                w_fd[p] = r_wb_result;
`else
                w_hz[p] = 1'b1;
`endif
            end
        end
    end

    assign bus.fwd_ra_valid_o = w_fv[0];
    assign bus.fwd_rb_valid_o = w_fv[1];
    assign bus.fwd_ra_o       = w_fd[0];
    assign bus.fwd_rb_o       = w_fd[1];
    assign bus.hazard_o       = |w_hz;

    assign bus.stall_o  = r_st[MEM_STAGE].valid & r_st[MEM_STAGE].lsu & ~bus.mem_complete_i;
    assign bus.squash_o = w_squash;

    assign w_valid_wb         = r_wb_valid & ~bus.issue_stall_i;
    assign bus.valid_wb_o     = w_valid_wb;
    assign bus.rd_wb_o        = (w_valid_wb & r_wb_rd_valid & ~bus.stall_o) ? r_wb_rd : 5'd0;
    assign bus.result_wb_o    = r_wb_result;
    assign bus.pc_wb_o        = r_wb_pc;
    assign bus.exception_wb_o = r_wb_exc;
endmodule

// File: tb/tb_biriscv_pipe_ctrl_nstage.sv
// ---------------------------------------------------------------------------
// tb_biriscv_pipe_ctrl_nstage
// Directed bench for biriscv_pipe_ctrl_nstage (STAGES=3, MEM_STAGE=2,
// MUL_STAGE=2). Expectations follow BIRISCV_PIPE_FWD_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_biriscv_pipe_ctrl_nstage;
`ifdef BIRISCV_PIPE_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic clk_i;
    logic rst_i;
    int   checks;
    int   errors;

    biriscv_pipe_ctrl_nstage_if bus ();

    biriscv_pipe_ctrl_nstage #(
        .STAGES    (3),
        .MEM_STAGE (2),
        .MUL_STAGE (2)
    ) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic set_issue(input logic v, input logic lsu, input logic mul,
                             input logic [4:0] rd, input logic [31:0] pc);
        bus.issue_valid_i    = v;
        bus.issue_lsu_i      = lsu;
        bus.issue_mul_i      = mul;
        bus.issue_rd_valid_i = 1'b1;
        bus.issue_rd_i       = rd;
        bus.issue_pc_i       = pc;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_i  = 1'b1;
        bus.issue_accept_i    = 1'b1;
        bus.issue_stall_i     = 1'b0;
        bus.issue_exception_i = 6'd0;
        bus.alu_result_e1_i   = 32'd0;
        bus.mem_complete_i    = 1'b0;
        bus.mem_result_i      = 32'd0;
        bus.mem_exception_i   = 6'd0;
        bus.mul_result_i      = 32'd0;
        bus.ra_i              = 5'd0;
        bus.rb_i              = 5'd0;
        bus.squash_wb_i       = 1'b0;
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Reset state
        tick(); tick();
        chk("rst_valid_wb", 32'(bus.valid_wb_o), 32'd0);
        chk("rst_squash",   32'(bus.squash_o),   32'd0);
        chk("rst_stall",    32'(bus.stall_o),    32'd0);
        rst_i = 1'b0;

        // Basic flow: ALU rd=5, 0x1234, pc 0x100
        set_issue(1'b1, 1'b0, 1'b0, 5'd5, 32'h100);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.alu_result_e1_i = 32'h1234;
        bus.ra_i = 5'd5;
        #1;
        chk("e1_fwd_valid", 32'(bus.fwd_ra_valid_o), FWD ? 32'd1 : 32'd0);
        chk("e1_fwd_val",   bus.fwd_ra_o,            FWD ? 32'h1234 : 32'd0);
        chk("e1_hazard",    32'(bus.hazard_o),       FWD ? 32'd0 : 32'd1);
        tick();
        bus.alu_result_e1_i = 32'd0;
        #1;
        chk("e2_ready_fwd", bus.fwd_ra_o,      FWD ? 32'h1234 : 32'd0);
        chk("e2_ready_hz",  32'(bus.hazard_o), FWD ? 32'd0 : 32'd1);
        tick(); tick();
        chk("wb_valid",  32'(bus.valid_wb_o), 32'd1);
        chk("wb_rd",     32'(bus.rd_wb_o),    32'd5);
        chk("wb_result", bus.result_wb_o,     32'h1234);
        chk("wb_pc",     bus.pc_wb_o,         32'h100);
        chk("wb_fwd",    bus.fwd_ra_o,        FWD ? 32'h1234 : 32'd0);
        tick();
        bus.ra_i = 5'd0;

        // Memory stall: load rd=7 waits 3 cycles in E2
        set_issue(1'b1, 1'b1, 1'b0, 5'd7, 32'h200);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.ra_i = 5'd7;
        #1;
        chk("ld_e1_hazard", 32'(bus.hazard_o), 32'd1);
        tick();
        chk("stall_c1", 32'(bus.stall_o),  32'd1);
        chk("haz_c1",   32'(bus.hazard_o), 32'd1);
        bus.issue_stall_i = 1'b1;
        tick();
        chk("stall_c2", 32'(bus.stall_o),  32'd1);
        tick();
        chk("stall_c3", 32'(bus.stall_o),  32'd1);
        chk("haz_c3",   32'(bus.hazard_o), 32'd1);
        bus.mem_complete_i = 1'b1;
        bus.mem_result_i   = 32'hCAFE;
        bus.issue_stall_i  = 1'b0;
        #1;
        chk("stall_done",    32'(bus.stall_o),        32'd0);
        chk("mem_fwd_valid", 32'(bus.fwd_ra_valid_o), FWD ? 32'd1 : 32'd0);
        chk("mem_fwd_val",   bus.fwd_ra_o,            FWD ? 32'hCAFE : 32'd0);
        chk("mem_fwd_hz",    32'(bus.hazard_o),       FWD ? 32'd0 : 32'd1);
        tick();
        bus.mem_complete_i = 1'b0;
        bus.mem_result_i   = 32'd0;
        tick();
        chk("ld_wb_rd",     32'(bus.rd_wb_o), 32'd7);
        chk("ld_wb_result", bus.result_wb_o,  32'hCAFE);
        tick();
        bus.ra_i = 5'd0;

        // Forwarding priority: rd=3 (0x11) then rd=3 (0x22)
        set_issue(1'b1, 1'b0, 1'b0, 5'd3, 32'h300);
        tick();
        bus.alu_result_e1_i = 32'h11;
        set_issue(1'b1, 1'b0, 1'b0, 5'd3, 32'h304);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.alu_result_e1_i = 32'h22;
        bus.rb_i = 5'd3;
        #1;
        chk("prio_rb_valid", 32'(bus.fwd_rb_valid_o), FWD ? 32'd1 : 32'd0);
        chk("prio_rb_val",   bus.fwd_rb_o,            FWD ? 32'h22 : 32'd0);
        chk("prio_ra0",      32'(bus.fwd_ra_valid_o), 32'd0);
        chk("prio_hz",       32'(bus.hazard_o),       FWD ? 32'd0 : 32'd1);
        bus.rb_i = 5'd0;
        #1;
        chk("r0_no_hz", 32'(bus.hazard_o), 32'd0);
        tick();
        bus.alu_result_e1_i = 32'd0;
        tick();
        chk("old_wb_result", bus.result_wb_o, 32'h11);
        chk("old_wb_pc",     bus.pc_wb_o,     32'h300);
        tick();
        chk("new_wb_result", bus.result_wb_o, 32'h22);
        tick();

        // Load exception: mem_exception_i=5 at E2, younger ALU dropped
        set_issue(1'b1, 1'b1, 1'b0, 5'd9, 32'h400);
        tick();
        set_issue(1'b1, 1'b0, 1'b0, 5'd10, 32'h404);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.mem_complete_i  = 1'b1;
        bus.mem_exception_i = 6'd5;
        bus.mem_result_i    = 32'hBEEF;
        bus.alu_result_e1_i = 32'h55;
        #1;
        chk("exc_pre_squash", 32'(bus.squash_o), 32'd0);
        tick();
        bus.mem_complete_i  = 1'b0;
        bus.mem_exception_i = 6'd0;
        bus.mem_result_i    = 32'd0;
        bus.alu_result_e1_i = 32'd0;
        set_issue(1'b1, 1'b0, 1'b0, 5'd11, 32'h408);
        #1;
        chk("squash_c1", 32'(bus.squash_o), 32'd1);
        tick();
        chk("squash_c2",   32'(bus.squash_o),       32'd1);
        chk("exc_wb_vld",  32'(bus.valid_wb_o),     32'd0);
        chk("exc_wb_code", 32'(bus.exception_wb_o), 32'd5);
        chk("exc_wb_rd",   32'(bus.rd_wb_o),        32'd0);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.ra_i = 5'd10;
        bus.rb_i = 5'd11;
        #1;
        chk("squash_end",   32'(bus.squash_o),       32'd0);
        chk("dropped_hz",   32'(bus.hazard_o),       32'd0);
        chk("dropped_fwd",  32'(bus.fwd_rb_valid_o), 32'd0);
        bus.ra_i = 5'd0;
        bus.rb_i = 5'd0;

        // Stall priority over WB kill
        set_issue(1'b1, 1'b0, 1'b0, 5'd12, 32'h500);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.alu_result_e1_i = 32'h77;
        tick();
        bus.alu_result_e1_i = 32'd0;
        tick(); tick();
        chk("k_wb_rd", 32'(bus.rd_wb_o), 32'd12);
        bus.issue_stall_i = 1'b1;
        bus.squash_wb_i   = 1'b1;
        #1;
        chk("k_stall_vld", 32'(bus.valid_wb_o), 32'd0);
        tick();
        chk("k_hold_pc",  bus.pc_wb_o,     32'h500);
        chk("k_hold_res", bus.result_wb_o, 32'h77);
        bus.issue_stall_i = 1'b0;
        #1;
        chk("k_unstall_rd", 32'(bus.rd_wb_o), 32'd12);
        tick();
        bus.squash_wb_i = 1'b0;
        chk("k_cleared", 32'(bus.valid_wb_o), 32'd0);

        // Multiply result captured leaving E2
        set_issue(1'b1, 1'b0, 1'b1, 5'd13, 32'h600);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.alu_result_e1_i = 32'hFFFF;
        bus.ra_i = 5'd13;
        #1;
        chk("mul_e1_hz", 32'(bus.hazard_o), 32'd1);
        tick();
        bus.alu_result_e1_i = 32'd0;
        bus.mul_result_i = 32'h3333;
        #1;
        chk("mul_e2_hz", 32'(bus.hazard_o), 32'd1);
        tick();
        bus.mul_result_i = 32'd0;
        #1;
        chk("mul_e3_fwd", bus.fwd_ra_o,      FWD ? 32'h3333 : 32'd0);
        chk("mul_e3_hz",  32'(bus.hazard_o), FWD ? 32'd0 : 32'd1);
        tick();
        chk("mul_wb_res", bus.result_wb_o, 32'h3333);
        tick();
        bus.ra_i = 5'd0;

        // Destination x0 never matches
        set_issue(1'b1, 1'b0, 1'b0, 5'd0, 32'h680);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.alu_result_e1_i = 32'h99;
        #1;
        chk("x0_hz",  32'(bus.hazard_o),       32'd0);
        chk("x0_fwd", 32'(bus.fwd_ra_valid_o), 32'd0);
        bus.alu_result_e1_i = 32'd0;
        tick(); tick(); tick(); tick();

        // Reset with entries in flight
        bus.alu_result_e1_i = 32'h1000;
        for (int i = 1; i <= 4; i++) begin
            set_issue(1'b1, 1'b0, 1'b0, 5'(i), 32'h700 + 32'(4 * i));
            tick();
        end
        set_issue(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.ra_i = 5'd2;
        #1;
        chk("pre_rst_vld", 32'(bus.valid_wb_o), 32'd1);
        chk("pre_rst_rd",  32'(bus.rd_wb_o),    32'd1);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_vld", 32'(bus.valid_wb_o),     32'd0);
        chk("mid_rst_rd",  32'(bus.rd_wb_o),        32'd0);
        chk("mid_rst_res", bus.result_wb_o,         32'd0);
        chk("mid_rst_pc",  bus.pc_wb_o,             32'd0);
        chk("mid_rst_exc", 32'(bus.exception_wb_o), 32'd0);
        chk("mid_rst_hz",  32'(bus.hazard_o),       32'd0);
        chk("mid_rst_fv",  32'(bus.fwd_ra_valid_o), 32'd0);
        chk("mid_rst_fd",  bus.fwd_ra_o,            32'd0);
        chk("mid_rst_sq",  32'(bus.squash_o),       32'd0);
        rst_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/biriscv_pipe_ctrl_nstage.md
# biriscv_pipe_ctrl_nstage

Parametrised in-order execution pipeline controller for biRISC-V, the successor of the fixed E1/E2/WB controller. It carries issued instructions through a configurable number of execute stages (E1..E`STAGES`) into a single writeback register. It captures ALU, load and multiply results at configurable stages, and generates the memory stall and exception squash. It also provides a two-operand RAW hazard/forwarding lookup for the issue stage. It sits between the issue/decode logic and the register file/CSR commit.

## Interface
- `STAGES`, 3, number of execute stages, 2..6; WB follows E`STAGES`.
- `MEM_STAGE`, 2, stage whose entry waits for `mem_complete_i` and captures `mem_result_i`; 1 < `MEM_STAGE` <= `STAGES`.
- `MUL_STAGE`, 2, stage that captures `mul_result_i`; 1 < `MUL_STAGE` <= `STAGES`.
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `issue_valid_i`, `issue_accept_i`, `issue_stall_i` in 1 each: issue handshake and global stall.
- `issue_lsu_i`, `issue_mul_i`, `issue_rd_valid_i` in 1 each: class bits and destination-valid flag.
- `issue_rd_i` in 5: destination register.
- `issue_pc_i` in 32: instruction PC.
- `issue_exception_i` in 6: front-end exception code; 0 = none.
- `alu_result_e1_i` in 32: ALU result for the E1 entry.
- `mem_complete_i` in 1, `mem_result_i` in 32, `mem_exception_i` in 6: LSU response for the `MEM_STAGE` entry.
- `mul_result_i` in 32: multiplier result for the `MUL_STAGE` entry.
- `ra_i`, `rb_i` in 5 each: source registers to check.
- `fwd_ra_valid_o`, `fwd_rb_valid_o` out 1 each: forward value valid.
- `fwd_ra_o`, `fwd_rb_o` out 32 each: forwarded values.
- `hazard_o` out 1: a source matches an in-flight result that is not ready yet.
- `stall_o` out 1: memory stall request.
- `squash_o` out 1: flush of younger stages.
- `squash_wb_i` in 1: external WB kill.
- `valid_wb_o` out 1, `rd_wb_o` out 5, `result_wb_o` out 32, `pc_wb_o` out 32, `exception_wb_o` out 6: commit outputs.

## Operation
- **Stage entry.** Each stage holds {valid, lsu, mul, rd_valid, rd, pc, exception, result, ready}.
- **Issue into E1.** E1 loads when `issue_valid_i & issue_accept_i & ~squash_o`. Otherwise E1 becomes invalid.
- **Capture rules.**
  - E1 ALU entries take `alu_result_e1_i` and `ready` is set on the E1→E2 move.
  - Load/store entries capture `mem_result_i` and `mem_exception_i` on leaving `MEM_STAGE`.
  - Multiply entries capture `mul_result_i` on leaving `MUL_STAGE`.
- **stall_o.** `stall_o = valid & lsu` at `MEM_STAGE` `& ~mem_complete_i`.
- **Global stall.** `issue_stall_i` freezes all stages and WB; the external stall logic ORs in `stall_o`.
- **Exceptions.** An entry's exception is its nonzero front-end code, else its mem code.
  - `squash_o` = (valid E`STAGES` entry with nonzero exception), OR its registered copy from the previous unstalled cycle.
  - While `squash_o`=1: E1..E`STAGES-1` are cleared and no issue is accepted.
  - The excepting entry enters WB with valid=0, rd_valid=0 and its exception code preserved.
- **Writeback.**
  - `squash_wb_i` clears WB.
  - `rd_wb_o = rd` when `valid_wb_o & rd_valid & ~stall_o`, else 0.
  - `valid_wb_o = valid_wb & ~issue_stall_i`.
- **Forwarding lookup.**
  - Search E1..E`STAGES` then WB, youngest first; the first valid rd_valid entry whose rd equals the source register wins. Register 0 never matches.
  - If the winner is ready, or is an E1 ALU entry (forward `alu_result_e1_i`), the forward valid is 1 with its value.
  - If the winner is a load at `MEM_STAGE` with `mem_complete_i`, forward `mem_result_i`.
  - Otherwise `hazard_o` = 1.

## Timing
- **Latency.** An instruction accepted at edge t is in E1 after t, in Ek after t+k-1, and in WB after t+`STAGES`, absent stalls.
- **Combinational outputs.** `squash_o`, `stall_o`, `hazard_o` and the forwarding outputs are combinational from state and inputs; there is zero-cycle lookup.
- **Squash duration.** `squash_o` lasts 2 unstalled cycles per exception.
- **Simultaneous events.**
  - Stall and squash together: stall wins; state is frozen and `squash_o` holds.
  - Stall and `squash_wb_i` together: stall wins.
- **Reset.** All valid bits, results, exceptions and the squash register are cleared, mid-operation included. Every output resets to 0.

## Configuration
- `BIRISCV_PIPE_FWD_EN`.
- **Defined:** forwarding network as described.
- **Undefined:** `fwd_*_valid_o`=0 and `fwd_*_o`=0; `hazard_o`=1 on any in-flight match (E1..WB).

## Test plan
- **Basic flow.** STAGES=3; issue ALU rd=5, `alu_result_e1_i`=0x1234 at pc 0x100 -> after 3 edges `valid_wb_o`=1, `rd_wb_o`=5, `result_wb_o`=0x1234, `pc_wb_o`=0x100.
- **Memory stall.** Load rd=7 reaches E2 with `mem_complete_i`=0 for 3 cycles -> `stall_o`=1 for 3 cycles. With `ra_i`=7 during that window -> `hazard_o`=1. On completion with 0xCAFE -> `fwd_ra_o`=0xCAFE and `fwd_ra_valid_o`=1.
- **Forwarding priority.** ALU rd=3 (0x11) followed by ALU rd=3 (0x22); query `rb_i`=3 -> `fwd_rb_o`=0x22. Query `ra_i`=0 -> no forward, no hazard.
- **Load exception.** Load gets `mem_exception_i`=5 at E2 -> `squash_o`=1 for 2 cycles and the younger E1 entry is dropped. WB shows `valid_wb_o`=0, `exception_wb_o`=5, `rd_wb_o`=0.
- **Stall priority and WB kill.** `issue_stall_i`=1 with `squash_wb_i`=1 -> WB unchanged. Deassert the stall -> WB cleared.
- **Reset and compile-out.** Assert `rst_i` with 3 entries in flight -> all outputs 0 next cycle. With `BIRISCV_PIPE_FWD_EN` undefined, a ready ALU match -> `hazard_o`=1.
